// File: rtl/sync_to_axis_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sync_to_axis_framer
// Purpose  : Turns the sync-qualified pixel stream of the eim_clk read path
//            into an AXI4-Stream video stream. Pixels are tagged with tuser
//            (first pixel of frame) and tlast (last pixel of line) and queued
//            in a small first-word-fall-through FIFO so the sink may apply
//            backpressure. Also owns the pixel/line counters that the timing
//            generator consumes.
// Ports    : eim_clk/eim_rst      clock, synchronous active-high reset
//            sig_vsync/sig_hsync  frame/line active from the timing generator
//            pix_data/pix_valid   pixel input, qualified by both syncs
//            max_h/max_v_count    frame geometry, latched at vsync rise
//            m_axis_*             AXI4-Stream master (tdata/tvalid/tready/
//                                 tuser/tlast)
//            s_h_count/s_v_count  registered pixel/line position
//            frame_done           one-cycle pulse after the last pixel
//            *_err / err_clr      sticky error flags and their clear
// Revision : 1.0 - initial release
// ============================================================================
module sync_to_axis_framer #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              eim_clk,
  input  logic              eim_rst,
  input  logic              sig_vsync,
  input  logic              sig_hsync,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_valid,
  input  logic [15:0]       max_h_count,
  input  logic [15:0]       max_v_count,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  output logic [15:0]       s_h_count,
  output logic [15:0]       s_v_count,
  output logic              frame_done,
  output logic              overflow_err,
  output logic              short_line_err,
  output logic              short_frame_err,
  input  logic              err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;       // extra bit separates full from empty
  localparam int EW = DATA_W + 2;   // {tuser, tlast, tdata}

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LINE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_PAD    = 2'd3
  } state_t;

  state_t      state_q;
  logic        vsync_1d_q;
  logic [15:0] h_q;
  logic [15:0] v_q;
  logic [15:0] h_lim_q;
  logic [15:0] v_lim_q;
  logic        frame_done_q;
  logic        overflow_err_q;
  logic        short_line_err_q;
  logic        short_frame_err_q;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_d;
  logic [PW-1:0] rd_ptr_d;

  logic          w_vs_rise;
  logic          w_accept;
  logic          w_pad_step;
  logic          w_advance;
  logic          w_line_end;
  logic          w_frame_end;
  logic          w_short_line;
  logic          w_short_frame;
  logic          w_full;
  logic          w_empty;
  logic          w_wr_en;
  logic          w_pop;
  logic [EW-1:0] w_wr_entry;
  logic [EW-1:0] w_rd_entry;

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  assign w_vs_rise = sig_vsync && !vsync_1d_q;

  assign w_accept = pix_valid && sig_vsync && sig_hsync &&
                    ((state_q == ST_LINE) || (state_q == ST_ACTIVE));

  // Padding never drops: it simply waits while the FIFO is full.
  assign w_pad_step = (state_q == ST_PAD) && sig_vsync && !w_full;

  // A dropped pixel still advances the position so tlast stays aligned.
  assign w_advance   = w_accept || w_pad_step;
  assign w_line_end  = w_advance && (h_q == h_lim_q - 16'd1);
  assign w_frame_end = w_line_end && (v_q == v_lim_q - 16'd1);

  assign w_short_frame = (state_q != ST_IDLE) && !sig_vsync;
  assign w_short_line  = (state_q == ST_ACTIVE) && sig_vsync && !sig_hsync &&
                         (h_q != 16'd0) && (h_q < h_lim_q);

  // Full/empty look at the pre-pop state, so a write into a full FIFO is
  // dropped even when a pop happens in the same cycle.
  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign w_wr_en = w_advance && !w_full && !eim_rst;
  assign w_pop   = !w_empty && m_axis_tready;

  always_comb begin
    w_wr_entry              = '0;
    w_wr_entry[EW-1]        = (h_q == 16'd0) && (v_q == 16'd0);
    w_wr_entry[EW-2]        = (h_q == h_lim_q - 16'd1);
    w_wr_entry[DATA_W-1:0]  = (state_q == ST_PAD) ? '0 : pix_data;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_wr_en) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Framing FSM, position counters and sticky errors
  // ---------------------------------------------------------------------------
  always_ff @(posedge eim_clk) begin
    if (eim_rst) begin
      state_q           <= ST_IDLE;
      vsync_1d_q        <= 1'b0;
      h_q               <= 16'd0;
      v_q               <= 16'd0;
      h_lim_q           <= 16'd1;
      v_lim_q           <= 16'd1;
      frame_done_q      <= 1'b0;
      overflow_err_q    <= 1'b0;
      short_line_err_q  <= 1'b0;
      short_frame_err_q <= 1'b0;
    end else begin
      vsync_1d_q   <= sig_vsync;
      frame_done_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (w_vs_rise) begin
            // Geometry is frozen for the whole frame; zero means one.
            h_lim_q <= (max_h_count == 16'd0) ? 16'd1 : max_h_count;
            v_lim_q <= (max_v_count == 16'd0) ? 16'd1 : max_v_count;
            h_q     <= 16'd0;
            v_q     <= 16'd0;
            state_q <= ST_LINE;
          end
        end
        default: begin
          if (w_short_frame) begin
            h_q     <= 16'd0;
            v_q     <= 16'd0;
            state_q <= ST_IDLE;
          end else if (w_advance) begin
            if (w_line_end) begin
              h_q <= 16'd0;
              if (w_frame_end) begin
                v_q          <= 16'd0;
                frame_done_q <= 1'b1;
                state_q      <= ST_IDLE;
              end else begin
                v_q     <= v_q + 16'd1;
                state_q <= ST_LINE;
              end
            end else begin
              h_q <= h_q + 16'd1;
              if (state_q == ST_LINE) begin
                state_q <= ST_ACTIVE;
              end
            end
          end else if (w_short_line) begin
            state_q <= ST_PAD;
          end
        end
      endcase

      // A new error event in the clearing cycle keeps the flag set.
      overflow_err_q    <= (overflow_err_q && !err_clr) || (w_accept && w_full);
      short_line_err_q  <= (short_line_err_q && !err_clr) || w_short_line;
      short_frame_err_q <= (short_frame_err_q && !err_clr) || w_short_frame;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO (registered storage, no write-to-read bypass)
  // ---------------------------------------------------------------------------
  always_ff @(posedge eim_clk) begin
    if (eim_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge eim_clk) begin
    if (w_wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= w_wr_entry;
    end
  end

  assign w_rd_entry = mem_q[rd_ptr_q[AW-1:0]];

  // Payload is forced to zero while empty so the bus is quiet after reset.
  assign m_axis_tvalid = !w_empty;
  assign m_axis_tdata  = w_empty ? '0   : w_rd_entry[DATA_W-1:0];
  assign m_axis_tuser  = w_empty ? 1'b0 : w_rd_entry[EW-1];
  assign m_axis_tlast  = w_empty ? 1'b0 : w_rd_entry[EW-2];

  assign s_h_count       = h_q;
  assign s_v_count       = v_q;
  assign frame_done      = frame_done_q;
  assign overflow_err    = overflow_err_q;
  assign short_line_err  = short_line_err_q;
  assign short_frame_err = short_frame_err_q;

endmodule
`default_nettype wire
